// File: rtl/vector_issue_sequencer.sv
// Vector issue sequencer: owns vl/vsew/vill, executes vsetvli and splits vector ops into lane-enabled beats.
// Optional build macro SEQ_SKIP_EMPTY_BEAT_EN suppresses beats whose lane_enable is all zero.
`ifndef SET_CFG
`define SET_CFG 3'b111
`endif

module vector_issue_sequencer #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int MAX_VL           = 64,
    parameter int VL_WIDTH         = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   chip_enabled,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_exe_signal,
    input  logic [10:0]            in_zimm,
    input  logic [4:0]             in_rs1_index,
    input  logic [4:0]             in_rd_index,
    input  logic [LEN-1:0]         in_avl,
    input  logic                   in_vm,
    input  logic [MAX_VL-1:0]      in_mask_bits,
    output logic                   beat_valid,
    input  logic                   beat_ready,
    output logic [VL_WIDTH-1:0]    beat_elem_base,
    output logic [VECTOR_SIZE-1:0] lane_enable,
    output logic                   beat_last,
    output logic                   cfg_wb_valid,
    output logic [4:0]             cfg_wb_index,
    output logic [LEN-1:0]         cfg_wb_data,
    output logic [VL_WIDTH-1:0]    vl_out,
    output logic [2:0]             vsew_out,
    output logic                   vill,
    output logic                   instr_done,
    output logic                   busy
);
    localparam logic [2:0]          SET_CFG_CODE = `SET_CFG;
    localparam logic [VL_WIDTH-1:0] BEAT_STEP    = VL_WIDTH'(1 << ENTRY_INDEX_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_ISSUE, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic [VL_WIDTH-1:0]   r_vl, r_base;
    logic [2:0]            r_vsew, r_new_sew;
    logic                  r_vill, r_rs1_nz;
    logic [4:0]            r_rd;
    logic [LEN-1:0]        r_avl;
    logic [MAX_VL-1:0]     r_mask;

    logic                  w_accept, w_is_cfg, w_advance, w_present, w_beat_last, w_cfg_vill;
    logic [VL_WIDTH-1:0]   w_vl_eff, w_vlmax, w_avl_clamped, w_cfg_vl;
    logic [MAX_VL-1:0]     w_vl_mask;
    logic [VECTOR_SIZE-1:0] w_lane_en;
    logic                  w_unused_bits;

    assign w_unused_bits = ^{in_zimm[10:6], in_zimm[2:0]};

    assign w_accept = in_valid && in_ready;
    assign w_is_cfg = (in_exe_signal == SET_CFG_CODE);
    assign w_vl_eff = r_vill ? '0 : r_vl;

    // Elements at or beyond vl are cleared at capture, so a beat's enables are just the low mask bits.
    generate
        for (genvar gi = 0; gi < MAX_VL; gi++) begin : g_vl_mask
            assign w_vl_mask[gi] = (VL_WIDTH'(gi) < w_vl_eff);
        end
    endgenerate

    assign w_vlmax       = VL_WIDTH'(MAX_VL) >> r_new_sew;
    assign w_avl_clamped = (r_avl < LEN'(w_vlmax)) ? r_avl[VL_WIDTH-1:0] : w_vlmax;
    assign w_cfg_vill    = (r_new_sew >= 3'd3);

    always_comb begin
        w_cfg_vl = r_vl;
        if (w_cfg_vill)
            w_cfg_vl = '0;
        else if (r_rs1_nz)
            w_cfg_vl = w_avl_clamped;
        else if (r_rd != 5'd0)
            w_cfg_vl = w_vlmax;
    end

    assign w_lane_en = r_mask[VECTOR_SIZE-1:0];

`ifdef SEQ_SKIP_EMPTY_BEAT_EN
    logic w_more, w_beat_empty;
    assign w_more       = |r_mask[MAX_VL-1:VECTOR_SIZE];
    assign w_beat_empty = (w_lane_en == '0);
    assign w_beat_last  = !w_more;
    assign w_present    = (r_state == S_ISSUE) && !w_beat_empty;
`else
    assign w_beat_last  = ((r_base + BEAT_STEP) >= w_vl_eff);
    assign w_present    = (r_state == S_ISSUE);
`endif

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_cfg)
                        w_state_next = S_CFG;
                    else if (w_vl_eff == '0)
                        w_state_next = S_DONE;
                    else
                        w_state_next = S_ISSUE;
                end
            end
            S_CFG:   w_state_next = S_DONE;
            S_ISSUE: begin
`ifdef SEQ_SKIP_EMPTY_BEAT_EN
                if (w_beat_empty) begin
                    if (!w_more)
                        w_state_next = S_DONE;
                    else
                        w_advance = 1'b1;
                end else if (beat_ready) begin
                    if (w_beat_last)
                        w_state_next = S_DONE;
                    else
                        w_advance = 1'b1;
                end
`else
                if (beat_ready) begin
                    if (w_beat_last)
                        w_state_next = S_DONE;
                    else
                        w_advance = 1'b1;
                end
`endif
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vl      <= '0;
            r_vsew    <= '0;
            r_vill    <= 1'b0;
            r_new_sew <= '0;
            r_rs1_nz  <= 1'b0;
            r_rd      <= '0;
            r_avl     <= '0;
            r_mask    <= '0;
            r_base    <= '0;
        end else if (chip_enabled) begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_new_sew <= in_zimm[5:3];
                r_rs1_nz  <= |in_rs1_index;
                r_rd      <= in_rd_index;
                r_avl     <= in_avl;
                r_mask    <= (in_vm ? {MAX_VL{1'b1}} : in_mask_bits) & w_vl_mask;
                r_base    <= '0;
            end
            if (r_state == S_CFG) begin
                r_vl   <= w_cfg_vl;
                r_vsew <= r_new_sew;
                r_vill <= w_cfg_vill;
            end
            if (w_advance) begin
                r_base <= r_base + BEAT_STEP;
                r_mask <= r_mask >> VECTOR_SIZE;
            end
        end
    end

    assign in_ready       = (r_state == S_IDLE) && chip_enabled;
    assign busy           = (r_state != S_IDLE);
    assign beat_valid     = w_present;
    assign beat_elem_base = w_present ? r_base : '0;
    assign lane_enable    = w_present ? w_lane_en : '0;
    assign beat_last      = w_present ? w_beat_last : 1'b0;
    assign cfg_wb_valid   = (r_state == S_CFG);
    assign cfg_wb_index   = (r_state == S_CFG) ? r_rd : 5'd0;
    assign cfg_wb_data    = (r_state == S_CFG) ? LEN'(w_cfg_vl) : '0;
    assign vl_out         = r_vl;
    assign vsew_out       = r_vsew;
    assign vill           = r_vill;
    assign instr_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Scoreboard bench for vector_issue_sequencer: directed scenarios followed by random instructions.
`ifndef SET_CFG
`define SET_CFG 3'b111
`endif

module tb_vector_issue_sequencer;
    logic        clk = 1'b0;
    logic        rst, chip_enabled, in_valid, in_ready, in_vm;
    logic [2:0]  in_exe_signal;
    logic [10:0] in_zimm;
    logic [4:0]  in_rs1_index, in_rd_index;
    logic [31:0] in_avl;
    logic [63:0] in_mask_bits;
    logic        beat_valid, beat_ready, beat_last;
    logic [6:0]  beat_elem_base, vl_out;
    logic [7:0]  lane_enable;
    logic        cfg_wb_valid, vill, instr_done, busy;
    logic [4:0]  cfg_wb_index;
    logic [31:0] cfg_wb_data;
    logic [2:0]  vsew_out;

    always #5 clk = ~clk;

    vector_issue_sequencer dut (
        .clk(clk), .rst(rst), .chip_enabled(chip_enabled),
        .in_valid(in_valid), .in_ready(in_ready), .in_exe_signal(in_exe_signal),
        .in_zimm(in_zimm), .in_rs1_index(in_rs1_index), .in_rd_index(in_rd_index),
        .in_avl(in_avl), .in_vm(in_vm), .in_mask_bits(in_mask_bits),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_elem_base(beat_elem_base),
        .lane_enable(lane_enable), .beat_last(beat_last),
        .cfg_wb_valid(cfg_wb_valid), .cfg_wb_index(cfg_wb_index), .cfg_wb_data(cfg_wb_data),
        .vl_out(vl_out), .vsew_out(vsew_out), .vill(vill),
        .instr_done(instr_done), .busy(busy)
    );

    typedef struct {
        int         kind;   // 0 beat, 1 cfg write, 2 done
        int         base;
        logic [7:0] en;
        logic       last;
        int         idx;
        int         data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_vl = 0, m_vsew = 0;
    bit   m_vill = 0;
    bit   ready_mode = 0, ready_force = 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    // Reference model: derives the expected event stream straight from the architectural rules.
    task automatic model(input logic [2:0] exe, input logic [10:0] zimm, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic [31:0] avl, input logic vm,
                         input logic [63:0] mask);
        exp_t e;
        exp_t beats[$];
        int   n, sew, vlmax;
        if (exe == `SET_CFG) begin
            sew = int'(zimm[5:3]);
            if (sew >= 3) begin
                m_vill = 1; m_vl = 0;
            end else begin
                m_vill = 0;
                vlmax  = 64 >> sew;
                if (rs1 != 0)     m_vl = (longint'(avl) < vlmax) ? int'(avl) : vlmax;
                else if (rd != 0) m_vl = vlmax;
            end
            m_vsew = sew;
            e = '{kind: 1, base: 0, en: 8'h00, last: 1'b0, idx: int'(rd), data: m_vl};
            exp_q.push_back(e);
        end else begin
            n = m_vill ? 0 : m_vl;
            for (int b = 0; b < n; b += 8) begin
                e = '{kind: 0, base: b, en: 8'h00, last: (b + 8 >= n), idx: 0, data: 0};
                for (int i = 0; i < 8; i++)
                    if ((b + i < n) && (vm || mask[b+i])) e.en[i] = 1'b1;
                beats.push_back(e);
            end
`ifdef SEQ_SKIP_EMPTY_BEAT_EN
            for (int k = beats.size() - 1; k >= 0; k--)
                if (beats[k].en == 8'h00) beats.delete(k);
            foreach (beats[k]) beats[k].last = (k == beats.size() - 1);
`endif
            foreach (beats[k]) exp_q.push_back(beats[k]);
        end
        e = '{kind: 2, base: 0, en: 8'h00, last: 1'b0, idx: 0, data: 0};
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        checks++;
        ok = 0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d, required none", kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_order: got kind %0d required kind %0d", kind, e.kind);
            end else ok = 1;
        end
    endtask

    // beat_ready changes just after the rising edge so the monitor sees the value used at the next edge.
    initial begin
        beat_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            beat_ready = ready_mode ? ($urandom_range(3) != 0) : ready_force;
        end
    end

    initial begin : monitor
        exp_t e;
        bit   ok;
        bit   prev_stall = 0;
        logic [6:0] p_base;
        logic [7:0] p_en;
        logic       p_last;
        forever begin
            @(negedge clk);
            if (!rst && chip_enabled) begin
                if (prev_stall) begin
                    chk("hold_valid", beat_valid, 1);
                    chk("hold_base", beat_elem_base, p_base);
                    chk("hold_enable", lane_enable, p_en);
                    chk("hold_last", beat_last, p_last);
                end
                if (beat_valid && beat_ready) begin
                    take(0, e, ok);
                    if (ok) begin
                        chk("beat_base", beat_elem_base, e.base);
                        chk("beat_enable", lane_enable, e.en);
                        chk("beat_last", beat_last, e.last);
                    end
                end
                if (cfg_wb_valid) begin
                    take(1, e, ok);
                    if (ok) begin
                        chk("cfg_wb_index", cfg_wb_index, e.idx);
                        chk("cfg_wb_data", cfg_wb_data, e.data);
                    end
                end
                if (instr_done) take(2, e, ok);
                prev_stall = beat_valid && !beat_ready;
                p_base = beat_elem_base; p_en = lane_enable; p_last = beat_last;
            end else prev_stall = 0;
        end
    end

    // Returns at 1ns after the accepting edge, i.e. in the first cycle after accept.
    task automatic send(input logic [2:0] exe, input logic [10:0] zimm, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic [31:0] avl, input logic vm,
                        input logic [63:0] mask);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1; in_exe_signal = exe; in_zimm = zimm; in_rs1_index = rs1;
        in_rd_index = rd; in_avl = avl; in_vm = vm; in_mask_bits = mask;
        @(posedge clk);
        #1;
        in_valid = 0;
        model(exe, zimm, rs1, rd, avl, vm, mask);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!instr_done && lat < 500) begin @(posedge clk); #1; lat++; end
        if (!instr_done) chk("done_timeout", 0, 1);
        chk("vl_out", vl_out, m_vl);
        chk("vill", vill, m_vill);
        if (!m_vill) chk("vsew_out", vsew_out, m_vsew);
    endtask

    function automatic logic [10:0] zsew(input int sew);
        logic [10:0] z;
        z = 11'd0;
        z[5:3] = 3'(sew);
        return z;
    endfunction

    localparam logic [2:0] ARITH = 3'd0;

    initial begin
        int lat, n;
        logic [7:0] f_en;
        logic [2:0] exe;
        logic [10:0] z;
        rst = 1; chip_enabled = 1; in_valid = 0; in_exe_signal = 0; in_zimm = 0;
        in_rs1_index = 0; in_rd_index = 0; in_avl = 0; in_vm = 0; in_mask_bits = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {beat_valid, busy, instr_done, cfg_wb_valid, beat_last, vill}, 0);
        chk("rst_vl", vl_out, 0);
        chk("rst_vsew", vsew_out, 0);
        chk("rst_beat", {beat_elem_base, lane_enable, cfg_wb_index, cfg_wb_data}, 0);
        rst = 0;
        #1 chk("ready_after_rst", in_ready, 1);

        // vsetvli sew=32, avl=20 -> vl=16
        send(`SET_CFG, zsew(2), 5'd1, 5'd5, 32'd20, 1'b1, 64'd0);
        chk("cfg_wb_at_1", cfg_wb_valid, 1);
        wait_done(lat);
        chk("cfg_done_lat", lat, 2);

        // vl=20, unmasked: three beats back to back
        send(`SET_CFG, zsew(0), 5'd3, 5'd0, 32'd20, 1'b1, 64'd0);
        wait_done(lat);
        send(ARITH, 11'd0, 5'd0, 5'd0, 32'd0, 1'b1, 64'd0);
        chk("first_beat_at_1", beat_valid, 1);
        wait_done(lat);
        chk("arith3_done_lat", lat, 4);

        // vl=16, masked, datapath stalls on beat 0
        send(`SET_CFG, zsew(0), 5'd2, 5'd0, 32'd16, 1'b1, 64'd0);
        wait_done(lat);
        ready_force = 0;
        @(posedge clk);
        send(ARITH, 11'd0, 5'd0, 5'd0, 32'd0, 1'b0, 64'h00F0);
        repeat (3) begin @(posedge clk); #1; end
        ready_force = 1;
        wait_done(lat);

        // vl=0: completes with no beats
        send(`SET_CFG, zsew(0), 5'd1, 5'd0, 32'd0, 1'b1, 64'd0);
        wait_done(lat);
        send(ARITH, 11'd0, 5'd0, 5'd0, 32'd0, 1'b1, 64'd0);
        wait_done(lat);
        chk("vl0_done_lat", lat, 1);

        // chip_enabled low freezes a presented beat
        send(`SET_CFG, zsew(0), 5'd1, 5'd0, 32'd20, 1'b1, 64'd0);
        wait_done(lat);
        send(ARITH, 11'd0, 5'd0, 5'd0, 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_0F3C);
        chip_enabled = 0;
        f_en = lane_enable;
        repeat (3) begin
            @(posedge clk); #1;
            chk("frz_in_ready", in_ready, 0);
            chk("frz_valid", beat_valid, 1);
            chk("frz_base", beat_elem_base, 0);
            chk("frz_enable", lane_enable, f_en);
        end
        chip_enabled = 1;
        wait_done(lat);

        // reset during beat 2 of 3
        send(ARITH, 11'd0, 5'd0, 5'd0, 32'd0, 1'b1, 64'd0);
        n = 0;
        while (!(beat_valid && beat_elem_base == 7'd16) && n < 20) begin @(posedge clk); #1; n++; end
        chk("reach_beat2", beat_elem_base, 16);
        rst = 1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_valid", beat_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_vl", vl_out, 0);
        chk("abort_done", instr_done, 0);
        rst = 0; m_vl = 0; m_vsew = 0; m_vill = 0;
        #1 chk("abort_ready", in_ready, 1);
        repeat (3) @(posedge clk);

        // illegal vtype then an arith op
        send(`SET_CFG, zsew(3), 5'd4, 5'd9, 32'd30, 1'b1, 64'd0);
        wait_done(lat);
        send(ARITH, 11'd0, 5'd0, 5'd0, 32'd0, 1'b1, 64'd0);
        wait_done(lat);
        chk("vill_done_lat", lat, 1);

        // random traffic with random back-pressure
        ready_mode = 1;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(2) == 0) begin
                z = 11'($urandom);
                z[5:3] = ($urandom_range(9) < 8) ? 3'($urandom_range(2)) : 3'($urandom_range(7, 3));
                send(`SET_CFG, z, ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                     5'($urandom), ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(80)),
                     1'b1, 64'd0);
            end else begin
                do exe = 3'($urandom); while (exe == `SET_CFG);
                send(exe, 11'($urandom), 5'($urandom), 5'($urandom), $urandom,
                     1'($urandom), {$urandom, $urandom});
            end
            wait_done(lat);
        end
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
